// File: rtl/rob_commit_if.sv
// Bundles the decoder, query, writeback and commit signals of the reorder buffer.
// The ROB takes the slave modport; the driving environment takes the master modport.
interface rob_commit_if #(
   parameter int ROB_BITS = 4
);
   logic                rdy_in;
   logic                dc_valid;
   logic [1:0]          dc_type;
   logic [4:0]          dc_rd;
   logic                dc_pred_taken;
   logic [31:0]         dc_alt_pc;
   logic                rob_full;
   logic [ROB_BITS-1:0] rob_tail;
   logic [ROB_BITS-1:0] qry1_id;
   logic [ROB_BITS-1:0] qry2_id;
   logic                qry1_ready;
   logic                qry2_ready;
   logic [31:0]         qry1_val;
   logic [31:0]         qry2_val;
   logic                rs_has_output;
   logic [ROB_BITS-1:0] rs_rob_id;
   logic [31:0]         rs_output;
   logic                has_jalr_new_pc;
   logic [31:0]         jalr_new_pc;
   logic                is_lsb;
   logic [ROB_BITS-1:0] lsb_rob_id;
   logic [31:0]         lsb_res;
   logic                commit_valid;
   logic [4:0]          commit_rd;
   logic [31:0]         commit_val;
   logic [ROB_BITS-1:0] commit_rob_id;
   logic                commit_store;
   logic                rob_clear;
   logic [31:0]         clear_pc;

   modport master (
      output rdy_in, dc_valid, dc_type, dc_rd, dc_pred_taken, dc_alt_pc,
             qry1_id, qry2_id, rs_has_output, rs_rob_id, rs_output,
             has_jalr_new_pc, jalr_new_pc, is_lsb, lsb_rob_id, lsb_res,
      input  rob_full, rob_tail, qry1_ready, qry2_ready, qry1_val, qry2_val,
             commit_valid, commit_rd, commit_val, commit_rob_id, commit_store,
             rob_clear, clear_pc
   );

   modport slave (
      input  rdy_in, dc_valid, dc_type, dc_rd, dc_pred_taken, dc_alt_pc,
             qry1_id, qry2_id, rs_has_output, rs_rob_id, rs_output,
             has_jalr_new_pc, jalr_new_pc, is_lsb, lsb_rob_id, lsb_res,
      output rob_full, rob_tail, qry1_ready, qry2_ready, qry1_val, qry2_val,
             commit_valid, commit_rd, commit_val, commit_rob_id, commit_store,
             rob_clear, clear_pc
   );
endinterface

// File: rtl/rob_commit.sv
// Reorder buffer: allocates tags at issue, captures RS/LSB writebacks, forwards operands,
// retires in program order and raises a one-cycle flush with a restart PC on redirect.
module rob_commit #(
   parameter int ROB_BITS = 4
) (
   input  logic         clk_in,
   input  logic         rst_in,
   rob_commit_if.slave  bus
);
   localparam int         ROB_SIZE = 1 << ROB_BITS;
   localparam logic [1:0] T_BR     = 2'd1;
   localparam logic [1:0] T_ST     = 2'd2;
   localparam logic [1:0] T_JALR   = 2'd3;

   logic [ROB_BITS-1:0] r_head;
   logic [ROB_BITS-1:0] r_tail;
   logic [ROB_BITS:0]   r_count;

   logic                r_busy   [ROB_SIZE];
   logic                r_ready  [ROB_SIZE];
   logic [1:0]          r_type   [ROB_SIZE];
   logic [4:0]          r_rd     [ROB_SIZE];
   logic                r_pred   [ROB_SIZE];
   logic [31:0]         r_alt_pc [ROB_SIZE];
   logic [31:0]         r_value  [ROB_SIZE];

   logic                r_commit_valid;
   logic                r_commit_store;
   logic                r_rob_clear;
   logic [4:0]          r_commit_rd;
   logic [31:0]         r_commit_val;
   logic [ROB_BITS-1:0] r_commit_rob_id;
   logic [31:0]         r_clear_pc;

   logic w_act;
   logic w_issue;
   logic w_rs_wb;
   logic w_lsb_wb;
   logic w_commit;
   logic w_redirect;
   logic w_no_rd;

   function automatic logic f_redirect(input logic [1:0] typ, input logic taken,
                                       input logic pred);
      return (typ == T_JALR) || ((typ == T_BR) && (taken != pred));
   endfunction

   // Stored value first, then same-cycle RS broadcast, then same-cycle LSB broadcast.
   function automatic logic [32:0] f_lookup(
      input logic                id,       input logic        busy,
      input logic                ready,    input logic [31:0] value,
      input logic                rs_v,     input logic        rs_hit,
      input logic [31:0]         rs_val,   input logic        lsb_v,
      input logic                lsb_hit,  input logic [31:0] lsb_val
   );
      if (!busy)           return 33'd0;
      if (ready)           return {1'b1, value};
      if (rs_v && rs_hit)  return {1'b1, rs_val};
      if (lsb_v && lsb_hit) return {1'b1, lsb_val};
      return {id, 32'd0} & 33'd0;
   endfunction

   // The flush cycle itself ignores issue, writeback and commit.
   assign w_act      = bus.rdy_in & ~r_rob_clear;
   assign w_issue    = w_act & bus.dc_valid;
   assign w_rs_wb    = w_act & bus.rs_has_output & r_busy[bus.rs_rob_id];
   assign w_lsb_wb   = w_act & bus.is_lsb & r_busy[bus.lsb_rob_id];
   assign w_commit   = w_act & r_busy[r_head] & r_ready[r_head];
   assign w_redirect = f_redirect(r_type[r_head], r_value[r_head][0], r_pred[r_head]);
   assign w_no_rd    = (r_type[r_head] == T_BR) || (r_type[r_head] == T_ST);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_head          <= '0;
         r_tail          <= '0;
         r_count         <= '0;
         r_commit_valid  <= 1'b0;
         r_commit_store  <= 1'b0;
         r_rob_clear     <= 1'b0;
         r_commit_rd     <= '0;
         r_commit_val    <= '0;
         r_commit_rob_id <= '0;
         r_clear_pc      <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            r_busy[i]  <= 1'b0;
            r_ready[i] <= 1'b0;
         end
      end else if (bus.rdy_in) begin
         if (r_rob_clear) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_store <= 1'b0;
            r_rob_clear    <= 1'b0;
            for (int i = 0; i < ROB_SIZE; i++) begin
               r_busy[i]  <= 1'b0;
               r_ready[i] <= 1'b0;
            end
         end else begin
            r_commit_valid <= w_commit;
            r_commit_store <= w_commit & (r_type[r_head] == T_ST);
            r_rob_clear    <= w_commit & w_redirect;
            if (w_commit) begin
               r_commit_rd     <= w_no_rd ? 5'd0 : r_rd[r_head];
               r_commit_val    <= r_value[r_head];
               r_commit_rob_id <= r_head;
               if (w_redirect) r_clear_pc <= r_alt_pc[r_head];
               r_busy[r_head]  <= 1'b0;
               r_head          <= r_head + 1'b1;
            end
            if (w_rs_wb)  r_ready[bus.rs_rob_id]  <= 1'b1;
            if (w_lsb_wb) r_ready[bus.lsb_rob_id] <= 1'b1;
            // Issue last: when full, the freed head slot is the new tail slot.
            if (w_issue) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= (bus.dc_type == T_ST);
               r_tail          <= r_tail + 1'b1;
            end
            r_count <= r_count + (ROB_BITS+1)'(w_issue) - (ROB_BITS+1)'(w_commit);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_act) begin
         if (w_rs_wb) begin
            r_value[bus.rs_rob_id] <= bus.rs_output;
            if (bus.has_jalr_new_pc) r_alt_pc[bus.rs_rob_id] <= bus.jalr_new_pc;
         end
         if (w_lsb_wb) r_value[bus.lsb_rob_id] <= bus.lsb_res;
         if (w_issue) begin
            r_type[r_tail]   <= bus.dc_type;
            r_rd[r_tail]     <= bus.dc_rd;
            r_pred[r_tail]   <= bus.dc_pred_taken;
            r_alt_pc[r_tail] <= bus.dc_alt_pc;
         end
      end
   end

   assign {bus.qry1_ready, bus.qry1_val} = f_lookup(
      1'b0, r_busy[bus.qry1_id], r_ready[bus.qry1_id], r_value[bus.qry1_id],
      bus.rs_has_output, bus.rs_rob_id == bus.qry1_id, bus.rs_output,
      bus.is_lsb, bus.lsb_rob_id == bus.qry1_id, bus.lsb_res);
   assign {bus.qry2_ready, bus.qry2_val} = f_lookup(
      1'b0, r_busy[bus.qry2_id], r_ready[bus.qry2_id], r_value[bus.qry2_id],
      bus.rs_has_output, bus.rs_rob_id == bus.qry2_id, bus.rs_output,
      bus.is_lsb, bus.lsb_rob_id == bus.qry2_id, bus.lsb_res);

   // Pulses are held while frozen and shown only when enabled, so each is seen once.
   assign bus.commit_valid  = r_commit_valid & bus.rdy_in;
   assign bus.commit_store  = r_commit_store & bus.rdy_in;
   assign bus.rob_clear     = r_rob_clear & bus.rdy_in;
   assign bus.commit_rd     = r_commit_rd;
   assign bus.commit_val    = r_commit_val;
   assign bus.commit_rob_id = r_commit_rob_id;
   assign bus.clear_pc      = r_clear_pc;
   assign bus.rob_full      = (r_count == (ROB_BITS+1)'(ROB_SIZE));
   assign bus.rob_tail      = r_tail;
endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: expected retirements are queued at issue and
// compared by a monitor whenever a commit pulse is observed.
module tb_rob_commit;
   logic clk_in = 1'b0;
   logic rst_in = 1'b0;

   rob_commit_if #(.ROB_BITS(4)) bus ();

   rob_commit #(.ROB_BITS(4)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  id;
      logic        st;
      logic        clr;
      logic [31:0] cpc;
   } exp_t;

   exp_t        sb[$];
   int          commit_cyc[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_store  = 0;
   int          cyc      = 0;
   logic [3:0]  m_tail   = 4'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk_in) cyc <= cyc + 1;

   // Commit monitor
   always @(negedge clk_in) begin
      if (!rst_in) begin
         if (bus.commit_store) n_store++;
         if (bus.rob_clear && !bus.commit_valid) chk("clear_alone", 32'(bus.commit_valid), 32'd1);
         if (bus.commit_valid) begin
            commit_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               chk("unexpected_commit", 32'(bus.commit_valid), 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
               chk("commit_id", 32'(bus.commit_rob_id), 32'(e.id));
               chk("commit_store", 32'(bus.commit_store), 32'(e.st));
               chk("rob_clear", 32'(bus.rob_clear), 32'(e.clr));
               if (!e.st) chk("commit_val", bus.commit_val, e.val);
               if (e.clr) chk("clear_pc", bus.clear_pc, e.cpc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic [1:0] typ, input logic [4:0] rd, input logic pred,
                        input logic [31:0] alt, input logic [31:0] val,
                        input logic [31:0] cpc, input bit push);
      exp_t e;
      bus.dc_valid      = 1'b1;
      bus.dc_type       = typ;
      bus.dc_rd         = rd;
      bus.dc_pred_taken = pred;
      bus.dc_alt_pc     = alt;
      if (push) begin
         e.rd  = (typ == 2'd1 || typ == 2'd2) ? 5'd0 : rd;
         e.val = val;
         e.id  = m_tail;
         e.st  = (typ == 2'd2);
         e.clr = (typ == 2'd3) || (typ == 2'd1 && val[0] != pred);
         e.cpc = cpc;
         sb.push_back(e);
      end
      m_tail++;
      step();
      bus.dc_valid = 1'b0;
   endtask

   task automatic wb(input bit lsb, input logic [3:0] id, input logic [31:0] val,
                     input bit jalr, input logic [31:0] npc);
      if (lsb) begin
         bus.is_lsb = 1'b1; bus.lsb_rob_id = id; bus.lsb_res = val;
      end else begin
         bus.rs_has_output = 1'b1; bus.rs_rob_id = id; bus.rs_output = val;
         bus.has_jalr_new_pc = jalr; bus.jalr_new_pc = npc;
      end
      step();
      bus.is_lsb = 1'b0; bus.rs_has_output = 1'b0; bus.has_jalr_new_pc = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (sb.size() != 0 && k < 200) begin
         step();
         k++;
      end
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bus.rdy_in = 1'b1;   bus.dc_valid = 1'b0;       bus.dc_type = 2'd0;
      bus.dc_rd = 5'd0;    bus.dc_pred_taken = 1'b0;  bus.dc_alt_pc = 32'd0;
      bus.qry1_id = 4'd0;  bus.qry2_id = 4'd0;        bus.rs_has_output = 1'b0;
      bus.rs_rob_id = 4'd0; bus.rs_output = 32'd0;    bus.has_jalr_new_pc = 1'b0;
      bus.jalr_new_pc = 32'd0; bus.is_lsb = 1'b0;     bus.lsb_rob_id = 4'd0;
      bus.lsb_res = 32'd0;
      #2 rst_in = 1'b1;
      repeat (2) step();
      chk("rst_cv", 32'(bus.commit_valid), 32'd0);
      chk("rst_clear", 32'(bus.rob_clear), 32'd0);
      chk("rst_full", 32'(bus.rob_full), 32'd0);
      chk("rst_tail", 32'(bus.rob_tail), 32'd0);
      rst_in = 1'b0;
      step();

      // Fill all 16 entries, then commit id0 while issuing into the freed slot
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("full_at15", 32'(bus.rob_full), 32'd0);
         issue(2'd0, 5'(i + 1), 1'b0, 32'd0, (i == 0) ? 32'hAA : 32'h100 + i, 32'd0, 1'b1);
      end
      chk("full_at16", 32'(bus.rob_full), 32'd1);
      chk("tail_at16", 32'(bus.rob_tail), 32'd0);
      wb(1'b0, 4'd0, 32'hAA, 1'b0, 32'd0);
      issue(2'd0, 5'd17, 1'b0, 32'd0, 32'h200, 32'd0, 1'b1);
      chk("full_keep", 32'(bus.rob_full), 32'd1);
      chk("tail_wrap", 32'(bus.rob_tail), 32'd1);
      for (int i = 1; i < 16; i++) wb(i[0] == 1'b0, 4'(i), 32'h100 + i, 1'b0, 32'd0);
      wb(1'b0, 4'd0, 32'h200, 1'b0, 32'd0);
      drain("drain_full");

      // Out-of-order writeback, in-order consecutive retirement
      commit_cyc.delete();
      issue(2'd0, 5'd5, 1'b0, 32'd0, 32'h11, 32'd0, 1'b1);
      issue(2'd0, 5'd6, 1'b0, 32'd0, 32'h22, 32'd0, 1'b1);
      issue(2'd0, 5'd7, 1'b0, 32'd0, 32'h33, 32'd0, 1'b1);
      wb(1'b0, 4'd3, 32'h33, 1'b0, 32'd0);
      wb(1'b1, 4'd2, 32'h22, 1'b0, 32'd0);
      wb(1'b0, 4'd1, 32'h11, 1'b0, 32'd0);
      drain("drain_ooo");
      chk("ooo_count", 32'(commit_cyc.size()), 32'd3);
      if (commit_cyc.size() == 3) begin
         chk("ooo_gap1", 32'(commit_cyc[1] - commit_cyc[0]), 32'd1);
         chk("ooo_gap2", 32'(commit_cyc[2] - commit_cyc[1]), 32'd1);
      end

      // Asynchronous reset with five busy entries
      for (int i = 0; i < 5; i++) issue(2'd0, 5'(20 + i), 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk("pre_rst_tail", 32'(bus.rob_tail), 32'd9);
      chk("pre_rst_rd", 32'(bus.commit_rd), 32'd7);
      rst_in = 1'b1;
      #1;
      chk("arst_tail", 32'(bus.rob_tail), 32'd0);
      chk("arst_full", 32'(bus.rob_full), 32'd0);
      chk("arst_rd", 32'(bus.commit_rd), 32'd0);
      chk("arst_val", bus.commit_val, 32'd0);
      chk("arst_id", 32'(bus.commit_rob_id), 32'd0);
      chk("arst_cv", 32'(bus.commit_valid), 32'd0);
      chk("arst_pc", bus.clear_pc, 32'd0);
      step();
      rst_in = 1'b0;
      m_tail = 4'd0;
      step();

      // Mispredicted branch at id0; the younger id1 must be squashed
      issue(2'd1, 5'd0, 1'b1, 32'h100, 32'd0, 32'h100, 1'b1);
      issue(2'd0, 5'd3, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      wb(1'b0, 4'd1, 32'h55, 1'b0, 32'd0);
      wb(1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      drain("drain_br");
      chk("flush_tail", 32'(bus.rob_tail), 32'd0);
      chk("flush_full", 32'(bus.rob_full), 32'd0);
      chk("flush_cv", 32'(bus.commit_valid), 32'd0);
      repeat (4) step();
      m_tail = 4'd0;

      // Operand queries: stored value, RS forward, LSB forward, non-busy entry
      issue(2'd0, 5'd8,  1'b0, 32'd0, 32'h7777, 32'd0, 1'b1);
      issue(2'd0, 5'd9,  1'b0, 32'd0, 32'h4444, 32'd0, 1'b1);
      issue(2'd0, 5'd10, 1'b0, 32'd0, 32'h5555, 32'd0, 1'b1);
      issue(2'd0, 5'd11, 1'b0, 32'd0, 32'h1234, 32'd0, 1'b1);
      wb(1'b0, 4'd1, 32'h4444, 1'b0, 32'd0);
      bus.qry1_id = 4'd3; bus.qry2_id = 4'd1;
      #1;
      chk("q1_not_ready", 32'(bus.qry1_ready), 32'd0);
      chk("q2_stored_rdy", 32'(bus.qry2_ready), 32'd1);
      chk("q2_stored_val", bus.qry2_val, 32'h4444);
      bus.rs_has_output = 1'b1; bus.rs_rob_id = 4'd3; bus.rs_output = 32'h1234;
      bus.is_lsb = 1'b1; bus.lsb_rob_id = 4'd2; bus.lsb_res = 32'h5555;
      #1;
      chk("q1_rs_rdy", 32'(bus.qry1_ready), 32'd1);
      chk("q1_rs_val", bus.qry1_val, 32'h1234);
      step();
      bus.rs_has_output = 1'b0;
      bus.qry1_id = 4'd0; bus.qry2_id = 4'd5;
      bus.is_lsb = 1'b1; bus.lsb_rob_id = 4'd0; bus.lsb_res = 32'h7777;
      #1;
      chk("q1_lsb_rdy", 32'(bus.qry1_ready), 32'd1);
      chk("q1_lsb_val", bus.qry1_val, 32'h7777);
      chk("q2_idle", 32'(bus.qry2_ready), 32'd0);
      step();
      bus.is_lsb = 1'b0;
      drain("drain_qry");

      // Correctly predicted branch, then jalr with a resolved target
      issue(2'd1, 5'd0, 1'b0, 32'h300, 32'd0, 32'd0, 1'b1);
      issue(2'd3, 5'd1, 1'b0, 32'h999, 32'h1004, 32'h2000, 1'b1);
      wb(1'b0, 4'd4, 32'd0, 1'b0, 32'd0);
      wb(1'b0, 4'd5, 32'h1004, 1'b1, 32'h2000);
      drain("drain_jalr");
      chk("jalr_tail", 32'(bus.rob_tail), 32'd0);
      m_tail = 4'd0;

      // Store issued across a two-cycle freeze, then frozen again before commit
      n_store = 0;
      begin
         exp_t e;
         e.rd = 5'd0; e.val = 32'd0; e.id = 4'd0; e.st = 1'b1; e.clr = 1'b0; e.cpc = 32'd0;
         sb.push_back(e);
      end
      bus.dc_valid = 1'b1; bus.dc_type = 2'd2; bus.dc_rd = 5'd9; bus.rdy_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("frz_tail", 32'(bus.rob_tail), 32'd0);
         chk("frz_store", 32'(bus.commit_store), 32'd0);
      end
      bus.rdy_in = 1'b1;
      step();
      bus.dc_valid = 1'b0;
      m_tail++;
      chk("st_tail", 32'(bus.rob_tail), 32'd1);
      bus.rdy_in = 1'b0;
      repeat (2) step();
      chk("frz2_store", 32'(bus.commit_store), 32'd0);
      bus.rdy_in = 1'b1;
      drain("drain_st");
      repeat (3) step();
      chk("store_pulses", 32'(n_store), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- 16-entry reorder buffer: the consumer of the reservation-station and load/store-buffer result broadcasts.
- Allocates an entry per decoded instruction and returns its ROB id as the destination tag. Captures writeback values and answers operand queries from the decoder.
- Commits in program order to the register file and the LSB.
- On branch misprediction at commit, drives the rob_clear flush and the recovery PC that the reservation station and other units consume.

Parameters:
ROB_BITS, 4, entry-id width; ROB_SIZE = 2**ROB_BITS = 16 entries

Ports:
clk_in  in  1  clock, rising edge
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global enable; low = freeze all state
dc_valid  in  1  decoder issues one instruction this cycle
dc_type  in  2  0=reg-write, 1=branch, 2=store, 3=jalr
dc_rd  in  5  destination register (x0 = no write)
dc_pred_taken  in  1  predicted direction (branch only)
dc_alt_pc  in  32  recovery PC if prediction wrong (branch only)
rob_full  out  1  no free entry
rob_tail  out  ROB_BITS  id the next issued instruction receives
qry1_id, qry2_id  in  ROB_BITS  operand tags to look up
qry1_ready, qry2_ready  out  1  value for tag available
qry1_val, qry2_val  out  32  that value
rs_has_output  in  1  RS/ALU broadcast valid
rs_rob_id  in  ROB_BITS  RS broadcast tag
rs_output  in  32  RS value (branch: bit0 = actual taken)
has_jalr_new_pc  in  1  jalr target valid with RS broadcast
jalr_new_pc  in  32  jalr target
is_lsb  in  1  LSB broadcast valid
lsb_rob_id  in  ROB_BITS  LSB tag
lsb_res  in  32  LSB value
commit_valid  out  1  one-cycle pulse: head retired
commit_rd  out  5  register written (0 for branch/store)
commit_val  out  32  value written
commit_rob_id  out  ROB_BITS  retired id (regfile clears matching dependency)
commit_store  out  1  one-cycle pulse: retired entry was a store; LSB may perform it
rob_clear  out  1  one-cycle flush pulse
clear_pc  out  32  fetch-restart PC, valid with rob_clear

Behaviour:
- State: circular buffer; head, tail (ROB_BITS, wrap naturally); count (ROB_BITS+1).
- Per entry: busy, ready, type, rd, pred, alt_pc, value.
- Reset (async): head=tail=count=0; all busy=0. Every registered output is 0: commit_valid, commit_store, rob_clear, commit_rd, commit_val, commit_rob_id, clear_pc.
- rdy_in low: all state held; commit_valid, commit_store and rob_clear are driven 0 (no duplicated pulses).
- rob_full = (count==16), combinational. rob_tail = tail, combinational.
- Issue:
  - On dc_valid (decoder guarantees !rob_full), entry[tail] gets busy=1, fields from dc_*; tail++, count++.
  - Stores get ready=1 at issue; all other types get ready=0.
- Writeback:
  - rs_has_output sets entry[rs_rob_id] ready=1, value=rs_output.
  - If has_jalr_new_pc, alt_pc=jalr_new_pc.
  - is_lsb sets entry[lsb_rob_id] ready=1, value=lsb_res.
  - The two writebacks never share a tag. A writeback to a non-busy entry is ignored.
- Query (combinational), per port:
  - ready = entry ready, OR rs_has_output with a matching tag, OR is_lsb with a matching tag.
  - val is chosen in that same priority order.
  - Only entries that are busy and ready count as available.
- Commit: at most one per cycle, when entry[head] is busy and ready. Outputs are registered; pulses appear in the next cycle.
  - reg-write: commit_valid=1, commit_rd=rd, commit_val=value.
  - jalr: commit_valid=1, commit_rd=rd, commit_val=value (link). Then rob_clear=1, clear_pc=alt_pc.
  - store: commit_valid=1, commit_store=1, commit_rd=0.
  - branch: commit_valid=1, commit_rd=0. If value[0] != pred, rob_clear=1, clear_pc=alt_pc.
  - In every case head++, count--.
- Simultaneous issue + commit: count unchanged; full stays full.
- Flush: the cycle rob_clear is high, the ROB itself flushes.
  - head=tail=count=0, all busy=0.
  - dc_valid, writebacks and commit are ignored that cycle.
  - Normal operation resumes the following cycle.
- Commit of a mispredicting entry blocks any further commit until the flush completes. Entries younger than the mispredicting one never retire.

Test Plan:
- Reset mid-operation with 5 busy entries -> all outputs 0 immediately (async); rob_tail=0; rob_full=0.
- Issue 16 reg-writes (rd=1..16 mod 32) with no writebacks -> rob_full=1 after the 16th. Then writeback id0=0xAA -> next cycle commit_valid, commit_rd=1, commit_val=0xAA, commit_rob_id=0. A simultaneous issue keeps rob_full=1 and sets tail=1 (wrap).
- Out-of-order writeback: ids 0,1,2 issued; writebacks 2,1,0 on successive cycles -> commits in order 0,1,2 on consecutive cycles.
- Query forwarding: qry1_id=3, entry 3 not ready, rs_has_output with rs_rob_id=3 and rs_output=0x1234 that same cycle -> qry1_ready=1, qry1_val=0x1234.
- Branch at id0 with pred_taken=1, alt_pc=0x100; RS value=0; reg-write at id1 ready -> commit branch, then rob_clear=1 with clear_pc=0x100. id1 never commits; the next cycle count=0, rob_tail=0.
- Store at id0, issued while rdy_in toggles low for 2 cycles -> exactly one commit_store pulse, after rdy_in returns high.
